// File: rtl/shot_pos_decoder_if.sv
// Byte-link input and decoded shot-position output bundle for shot_pos_decoder.
interface shot_pos_decoder_if;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [9:0] shot_xpos;
  logic [9:0] shot_ypos;
  logic       pos_valid;
  logic       pos_locked;
  logic [7:0] frame_err_cnt;

  modport master (
    output enable, rx_data, rx_valid,
    input  shot_xpos, shot_ypos, pos_valid, pos_locked, frame_err_cnt
  );

  modport slave (
    input  enable, rx_data, rx_valid,
    output shot_xpos, shot_ypos, pos_valid, pos_locked, frame_err_cnt
  );
endinterface

// File: rtl/shot_pos_decoder.sv
// Reassembles tagged 4-byte shot-position frames and commits x/y only after
// CONFIRM_FRAMES consecutive identical frames; commit lands 2 cycles after the last byte.
module shot_pos_decoder #(
  parameter int CONFIRM_FRAMES = 2,
  parameter int TIMEOUT_CYCLES = 650000
) (
  input  logic              clk,
  input  logic              rst,
  shot_pos_decoder_if.slave bus
);
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    CONFIRM = 4'(CONFIRM_FRAMES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {WAIT_XL, WAIT_XH, WAIT_YL, WAIT_YH, CHECK} state_t;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  state_t        state;
  state_t        next_state;
  pos_t          partial;
  pos_t          candidate;
  logic [3:0]    match_cnt;
  logic [3:0]    match_next;
  logic [TW-1:0] idle_cnt;
  logic [2:0]    exp_tag;
  logic [2:0]    tag;
  logic [4:0]    payload;
  logic          byte_in;
  logic          timeout_hit;
  logic          err_evt;
  logic [9:0]    xpos;
  logic [9:0]    ypos;
  logic          valid;
  logic          locked;
  logic [7:0]    err_cnt;

  assign tag     = bus.rx_data[2:0];
  assign payload = bus.rx_data[7:3];

  always_comb begin
    exp_tag    = 3'b001;
    next_state = WAIT_XH;
    case (state)
      WAIT_XH: begin exp_tag = 3'b010; next_state = WAIT_YL; end
      WAIT_YL: begin exp_tag = 3'b101; next_state = WAIT_YH; end
      WAIT_YH: begin exp_tag = 3'b110; next_state = CHECK;   end
      default: ;
    endcase
  end

  // The transmitter never strobes during CHECK, so a byte there is simply ignored.
  assign byte_in     = bus.enable && bus.rx_valid && (state != CHECK);
  assign timeout_hit = bus.enable && !bus.rx_valid && (idle_cnt == TO_LAST) &&
                       (state inside {WAIT_XH, WAIT_YL, WAIT_YH});
  assign err_evt     = (byte_in && (tag != exp_tag)) || timeout_hit;

  assign match_next = (partial != candidate) ? 4'd1 :
                      (match_cnt >= CONFIRM) ? CONFIRM : match_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_XL;
      partial   <= '0;
      candidate <= '0;
      match_cnt <= '0;
      idle_cnt  <= '0;
      xpos      <= '0;
      ypos      <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
    end else if (!bus.enable) begin
      state     <= WAIT_XL;
      partial   <= '0;
      candidate <= '0;
      match_cnt <= '0;
      idle_cnt  <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (err_evt && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;

      if (state == CHECK) begin
        match_cnt <= match_next;
        candidate <= partial;
        // Position registers and the strobe move together so consumers never see a torn x/y pair.
        if (match_next == CONFIRM) begin
          xpos   <= partial.x;
          ypos   <= partial.y;
          valid  <= 1'b1;
          locked <= 1'b1;
        end
        state <= WAIT_XL;
      end else if (byte_in) begin
        idle_cnt <= '0;
        if ((tag == exp_tag) || (tag == 3'b001)) begin
          case (tag)
            3'b001:  partial.x[4:0] <= payload;
            3'b010:  partial.x[9:5] <= payload;
            3'b101:  partial.y[4:0] <= payload;
            3'b110:  partial.y[9:5] <= payload;
            default: ;
          endcase
        end
        // A stray x-low byte is treated as the start of a fresh frame to realign quickly.
        if (tag == exp_tag)
          state <= next_state;
        else if (tag == 3'b001)
          state <= WAIT_XH;
        else
          state <= WAIT_XL;
      end else if (state != WAIT_XL) begin
        if (timeout_hit) begin
          idle_cnt <= '0;
          state    <= WAIT_XL;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.shot_xpos     = xpos;
  assign bus.shot_ypos     = ypos;
  assign bus.pos_valid     = valid;
  assign bus.pos_locked    = locked;
  assign bus.frame_err_cnt = err_cnt;
endmodule
